// File: rtl/julia_pkg.sv
// Shared types and constants for the julia pixel write path.
package julia_pkg;

    localparam int NUM_WORKERS  = 16;
    localparam int FRAME_PIXELS = 307200;
    localparam int PIX_CNT_W    = 19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } mc_state_t;

endpackage

// File: rtl/julia_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int NUM_WORKERS = 16,
    localparam int IDX_W       = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1
) (
    input  logic [NUM_WORKERS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [NUM_WORKERS-1:0] gnt,
    output logic [IDX_W-1:0]       gnt_idx,
    output logic                   any
);

    // Scan lanes starting at ptr; the first requesting lane wins.
    always_comb begin
        int  idx;
        logic hit;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        hit     = 1'b0;
        for (int k = 0; k < NUM_WORKERS; k++) begin
            idx      = (int'(ptr) + k) % NUM_WORKERS;
            hit      = req[idx] & ~any;
            gnt[idx] = hit;
            gnt_idx  = hit ? IDX_W'(idx) : gnt_idx;
            any      = any | hit;
        end
    end

endmodule

// File: rtl/julia_write_arbiter.sv
// Serialises finished worker pixels onto the single-beat write port with
// round-robin fairness, and counts completed writes per frame.
module julia_write_arbiter #(
    parameter int NUM_WORKERS  = julia_pkg::NUM_WORKERS,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int FRAME_PIXELS = julia_pkg::FRAME_PIXELS
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_WORKERS-1:0]              jw_done,
    input  logic [NUM_WORKERS-1:0][DATA_W-1:0]  color,
    input  logic [NUM_WORKERS-1:0][ADDR_W-1:0]  address,
    output logic [NUM_WORKERS-1:0]              mc_busy,
    output logic [NUM_WORKERS-1:0]              mc_done,
    output logic [ADDR_W-1:0]                   wr_addr,
    output logic [DATA_W-1:0]                   wr_data,
    output logic                                wr_ready,
    input  logic                                wr_done,
    output logic [julia_pkg::PIX_CNT_W-1:0]     pix_count,
    output logic                                frame_done
);
    import julia_pkg::*;

    localparam int IDX_W = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;

    mc_state_t              state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_WORKERS-1:0] mask_q, mask_d;
    logic [NUM_WORKERS-1:0] mc_busy_q, mc_busy_d;
    logic [NUM_WORKERS-1:0] mc_done_q, mc_done_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]      wr_data_q, wr_data_d;
    logic                   wr_ready_q, wr_ready_d;
    logic [PIX_CNT_W-1:0]   pix_count_q, pix_count_d;
    logic                   frame_done_q, frame_done_d;

    logic [NUM_WORKERS-1:0] req_s;
    logic [NUM_WORKERS-1:0] gnt_s;
    logic [IDX_W-1:0]       gnt_idx_s;
    logic                   any_s;
    logic [NUM_WORKERS-1:0] grant_oh_s;

    // The just-served worker is masked for one IDLE cycle in case its request drops late.
    assign req_s      = jw_done & ~mask_q;
    assign grant_oh_s = {{(NUM_WORKERS-1){1'b0}}, 1'b1} << grant_q;

    rr_arbiter #(.NUM_WORKERS(NUM_WORKERS)) u_rr_arbiter (
        .req     (req_s),
        .ptr     (rr_ptr_q),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any     (any_s)
    );

    // Next-state and registered-output logic for the grant/write/ack sequence.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        mask_d       = mask_q;
        mc_busy_d    = mc_busy_q;
        mc_done_d    = '0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_ready_d   = wr_ready_q;
        pix_count_d  = pix_count_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                mask_d = '0;
                if (any_s) begin
                    grant_d    = gnt_idx_s;
                    mc_busy_d  = gnt_s;
                    wr_addr_d  = address[gnt_idx_s];
                    wr_data_d  = color[gnt_idx_s];
                    wr_ready_d = 1'b1;
                    state_d    = WRITE;
                end else begin
                    mc_busy_d  = '0;
                    wr_ready_d = 1'b0;
                end
            end
            WRITE: begin
                if (wr_done) begin
                    wr_ready_d = 1'b0;
                    mc_done_d  = grant_oh_s;
                    if (pix_count_q == PIX_CNT_W'(FRAME_PIXELS - 1)) begin
                        pix_count_d  = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        pix_count_d  = pix_count_q + PIX_CNT_W'(1);
                    end
                    rr_ptr_d = (grant_q == IDX_W'(NUM_WORKERS - 1)) ? '0 : grant_q + IDX_W'(1);
                    state_d  = ACK;
                end else begin
                    state_d = WRITE;
                end
            end
            ACK: begin
                mc_busy_d = '0;
                mask_d    = grant_oh_s;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            mask_q       <= '0;
            mc_busy_q    <= '0;
            mc_done_q    <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_ready_q   <= 1'b0;
            pix_count_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            mask_q       <= mask_d;
            mc_busy_q    <= mc_busy_d;
            mc_done_q    <= mc_done_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_ready_q   <= wr_ready_d;
            pix_count_q  <= pix_count_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign mc_busy    = mc_busy_q;
    assign mc_done    = mc_done_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_ready   = wr_ready_q;
    assign pix_count  = pix_count_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_julia_write_arbiter.sv
// Self-checking bench for julia_write_arbiter against a queue/arithmetic model.
module tb_julia_write_arbiter;

    localparam int NW = 16;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int FP = 4;

    logic                   clk;
    logic                   rst;
    logic [NW-1:0]          jw_done;
    logic [NW-1:0][DW-1:0]  color;
    logic [NW-1:0][AW-1:0]  address;
    logic [NW-1:0]          mc_busy;
    logic [NW-1:0]          mc_done;
    logic [AW-1:0]          wr_addr;
    logic [DW-1:0]          wr_data;
    logic                   wr_ready;
    logic                   wr_done;
    logic [18:0]            pix_count;
    logic                   frame_done;

    int checks = 0;
    int passes = 0;
    int m_ptr  = 0;
    int m_pix  = 0;
    int fd_count = 0;
    int got_order[$];

    julia_write_arbiter #(
        .NUM_WORKERS(NW), .DATA_W(DW), .ADDR_W(AW), .FRAME_PIXELS(FP)
    ) dut (
        .clk(clk), .rst(rst), .jw_done(jw_done), .color(color), .address(address),
        .mc_busy(mc_busy), .mc_done(mc_done), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .wr_done(wr_done), .pix_count(pix_count),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference pick: first requester at or after ptr, wrapping.
    function automatic int pick(input logic [NW-1:0] r, input int p);
        for (int k = 0; k < NW; k++) begin
            if (r[(p + k) % NW]) return (p + k) % NW;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ptr = 0;
        m_pix = 0;
    endtask

    // Hold a request set with wr_done high; workers drop their bit one cycle late.
    task automatic run_traffic(input logic [NW-1:0] reqs);
        logic [NW-1:0] pending;
        logic [NW-1:0] oh;
        int  n, budget, cur, exp, last_start, starts, dones, drop_idx, drop_in;
        bit  prev_rdy, exp_fd;
        pending = reqs; n = $countones(reqs); budget = 3 * n + 4;
        cur = -1; last_start = 0; starts = 0; dones = 0; drop_idx = 0; drop_in = 0;
        got_order.delete();
        prev_rdy = wr_ready;
        jw_done = reqs;
        wr_done = 1'b1;
        for (int t = 0; t < budget; t++) begin
            tick();
            if (drop_in > 0) begin
                drop_in--;
                if (drop_in == 0) jw_done[drop_idx] = 1'b0;
            end
            exp_fd = 1'b0;
            if (wr_ready && !prev_rdy) begin
                exp = pick(pending, m_ptr);
                checks++;
                if (exp < 0) begin
                    $display("FAIL rr_spurious_grant got mc_busy=%h expected no grant", mc_busy);
                end else begin
                    oh = 16'h0001 << exp;
                    if ({mc_busy, wr_addr, wr_data} !== {oh, address[exp], color[exp]})
                        $display("FAIL rr_grant got busy=%h addr=%h data=%h expected busy=%h addr=%h data=%h",
                                 mc_busy, wr_addr, wr_data, oh, address[exp], color[exp]);
                    else passes++;
                    if (starts > 0) begin
                        checks++;
                        if (t - last_start != 3)
                            $display("FAIL rr_spacing got %0d expected 3", t - last_start);
                        else passes++;
                    end
                    last_start = t; starts++; cur = exp;
                    got_order.push_back(exp);
                end
            end
            if (mc_done != '0) begin
                checks++;
                if (cur < 0) begin
                    $display("FAIL rr_done_without_grant got mc_done=%h expected 0", mc_done);
                end else begin
                    oh = 16'h0001 << cur;
                    m_pix  = (m_pix + 1) % FP;
                    exp_fd = (m_pix == 0);
                    if ({mc_done, wr_ready, pix_count} !== {oh, 1'b0, 19'(m_pix)})
                        $display("FAIL rr_done got done=%h rdy=%b pix=%0d expected done=%h rdy=0 pix=%0d",
                                 mc_done, wr_ready, pix_count, oh, m_pix);
                    else passes++;
                    pending[cur] = 1'b0;
                    m_ptr = (cur + 1) % NW;
                    drop_idx = cur; drop_in = 2;
                end
                dones++;
            end
            if (frame_done === 1'b1) fd_count++;
            checks++;
            if (frame_done !== exp_fd)
                $display("FAIL rr_frame_done got %b expected %b", frame_done, exp_fd);
            else passes++;
            prev_rdy = wr_ready;
        end
        wr_done = 1'b0;
        jw_done = '0;
        checks++;
        if (dones != n || pending != '0)
            $display("FAIL rr_done_count got %0d expected %0d", dones, n);
        else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1; jw_done = '0; wr_done = 1'b0; color = '0; address = '0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if ({mc_busy, mc_done, wr_ready, frame_done, wr_addr, wr_data, pix_count} !== '0)
            $display("FAIL reset_outputs got busy=%h done=%h rdy=%b fd=%b addr=%h data=%h pix=%0d expected all 0",
                     mc_busy, mc_done, wr_ready, frame_done, wr_addr, wr_data, pix_count);
        else passes++;
        m_ptr = 0; m_pix = 0;
    endtask

    task automatic test_single();
        address[0] = 32'h0000_0100;
        color[0]   = 32'h00FF_00FF;
        jw_done    = 16'h0001;
        tick();
        checks++;
        if ({wr_ready, wr_addr, wr_data, mc_busy} !== {1'b1, 32'h100, 32'hFF00FF, 16'h0001})
            $display("FAIL single_grant got rdy=%b addr=%h data=%h busy=%h expected 1 100 ff00ff 0001",
                     wr_ready, wr_addr, wr_data, mc_busy);
        else passes++;
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        jw_done = '0;
        checks++;
        if ({mc_done, wr_ready, pix_count} !== {16'h0001, 1'b0, 19'd1})
            $display("FAIL single_done got done=%h rdy=%b pix=%0d expected 0001 0 1", mc_done, wr_ready, pix_count);
        else passes++;
        tick();
        checks++;
        if ({mc_done, mc_busy} !== 32'h0)
            $display("FAIL single_done_pulse got done=%h busy=%h expected 0 0", mc_done, mc_busy);
        else passes++;
        m_ptr = 1; m_pix = 1;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < NW; i++) begin
            color[i]   = $urandom;
            address[i] = $urandom;
        end
        do_reset();
        run_traffic(16'hFFFF);
        checks++;
        if (got_order.size() != NW) $display("FAIL rr_order_len got %0d expected %0d", got_order.size(), NW);
        else passes++;
        for (int i = 0; i < got_order.size(); i++) begin
            checks++;
            if (got_order[i] != i) $display("FAIL rr_order got %0d expected %0d", got_order[i], i);
            else passes++;
        end
    endtask

    task automatic test_fairness();
        int exp_order[3] = '{14, 0, 1};
        run_traffic(16'h2000);
        run_traffic(16'h4003);
        checks++;
        if (got_order.size() != 3) $display("FAIL wrap_order_len got %0d expected 3", got_order.size());
        else passes++;
        for (int i = 0; i < 3 && i < got_order.size(); i++) begin
            checks++;
            if (got_order[i] != exp_order[i]) $display("FAIL wrap_order got %0d expected %0d", got_order[i], exp_order[i]);
            else passes++;
        end
    endtask

    task automatic test_stall();
        int g;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [NW-1:0] oh;
        g = $urandom_range(0, NW - 1);
        ea = $urandom; ed = $urandom;
        address[g] = ea; color[g] = ed;
        oh = 16'h0001 << g;
        jw_done = oh; wr_done = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                color[g]   = ~ed;
                address[g] = ~ea;
            end
            checks++;
            if ({wr_ready, mc_busy, mc_done, wr_addr, wr_data} !== {1'b1, oh, 16'h0, ea, ed})
                $display("FAIL stall_hold got rdy=%b busy=%h done=%h addr=%h data=%h expected 1 %h 0 %h %h",
                         wr_ready, mc_busy, mc_done, wr_addr, wr_data, oh, ea, ed);
            else passes++;
            tick();
        end
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0; jw_done = '0;
        m_pix = (m_pix + 1) % FP;
        checks++;
        if ({mc_done, pix_count, frame_done} !== {oh, 19'(m_pix), (m_pix == 0)})
            $display("FAIL stall_done got done=%h pix=%0d fd=%b expected %h %0d %b",
                     mc_done, pix_count, frame_done, oh, m_pix, (m_pix == 0));
        else passes++;
        tick();
        m_ptr = (g + 1) % NW;
    endtask

    task automatic test_ignore_wr_done();
        jw_done = '0; wr_done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({wr_ready, mc_done, pix_count} !== {1'b0, 16'h0, 19'(m_pix)})
                $display("FAIL idle_wr_done got rdy=%b done=%h pix=%0d expected 0 0 %0d", wr_ready, mc_done, pix_count, m_pix);
            else passes++;
        end
        wr_done = 1'b0;
        tick();
    endtask

    task automatic test_frame_wrap();
        do_reset();
        fd_count = 0;
        run_traffic(16'h000F);
        checks++;
        if (fd_count != 1 || pix_count !== 19'd0)
            $display("FAIL frame_wrap got fd_pulses=%0d pix=%0d expected 1 0", fd_count, pix_count);
        else passes++;
        run_traffic(16'h0010);
        checks++;
        if (pix_count !== 19'd1) $display("FAIL frame_after_wrap got %0d expected 1", pix_count);
        else passes++;
    endtask

    task automatic test_reset_mid_write();
        jw_done = 16'h0020; wr_done = 1'b0;
        tick();
        checks++;
        if (wr_ready !== 1'b1) $display("FAIL midrst_pre got rdy=%b expected 1", wr_ready);
        else passes++;
        rst = 1'b1;
        jw_done = 16'h0108;
        tick();
        rst = 1'b0;
        checks++;
        if ({mc_busy, mc_done, wr_ready, frame_done, wr_addr, wr_data, pix_count} !== '0)
            $display("FAIL midrst_outputs got busy=%h done=%h rdy=%b fd=%b addr=%h data=%h pix=%0d expected all 0",
                     mc_busy, mc_done, wr_ready, frame_done, wr_addr, wr_data, pix_count);
        else passes++;
        tick();
        checks++;
        if ({mc_busy, wr_ready, wr_addr, wr_data} !== {16'h0008, 1'b1, address[3], color[3]})
            $display("FAIL midrst_grant got busy=%h rdy=%b addr=%h expected 0008 1 %h", mc_busy, wr_ready, wr_addr, address[3]);
        else passes++;
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0; jw_done = '0;
        checks++;
        if ({mc_done, pix_count} !== {16'h0008, 19'd1})
            $display("FAIL midrst_done got done=%h pix=%0d expected 0008 1", mc_done, pix_count);
        else passes++;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_stall();
        test_ignore_wr_done();
        test_frame_wrap();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/julia_write_arbiter.md
# julia_write_arbiter

Collects finished pixels from the julia worker array and serialises them onto the single-beat pixel write port. It is the responder side of the worker done/busy/done handshake and the initiator of the `wr_ready`/`wr_done` write port. Requests are granted round-robin across workers, and completed writes are counted per frame. It sits between the worker array and the frame-buffer write master, inside the julia top-level wrapper.

## Interface
Parameters:
- `NUM_WORKERS`, 16: number of worker request lanes.
- `DATA_W`, 32: pixel colour width.
- `ADDR_W`, 32: write address width.
- `FRAME_PIXELS`, 307200: writes per frame (640x480).

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, synchronous and active-high.
- `jw_done` in `NUM_WORKERS`: worker i has a pixel ready and holds `color[i]`/`address[i]` stable.
- `color` in `NUM_WORKERS` x `DATA_W`: per-worker pixel colour.
- `address` in `NUM_WORKERS` x `ADDR_W`: per-worker pixel address.
- `mc_busy` out `NUM_WORKERS`: one-hot; high for the granted worker during WRITE and ACK.
- `mc_done` out `NUM_WORKERS`: one-hot, one-cycle pulse; write of worker i has completed.
- `wr_addr` out `ADDR_W`: write address.
- `wr_data` out `DATA_W`: write data.
- `wr_ready` out 1: write request valid.
- `wr_done` in 1: write master accepted the current request.
- `pix_count` out 19: writes completed in the current frame.
- `frame_done` out 1: one-cycle pulse when the last pixel of a frame completes.

## Operation
- FSM states are IDLE, WRITE and ACK.
- **IDLE:**
  - Form `req = jw_done & ~mask`.
  - If `req` is nonzero, pick the first set bit at or after `rr_ptr`, wrapping modulo `NUM_WORKERS`.
  - Register `grant`, `wr_addr <= address[grant]`, `wr_data <= color[grant]` and `wr_ready <= 1`, then go to WRITE.
- **WRITE:**
  - Hold `wr_ready`, `wr_addr` and `wr_data` stable.
  - On `wr_done`: `wr_ready <= 0`, `mc_done[grant] <= 1`, increment `pix_count`, `rr_ptr <= (grant+1) mod NUM_WORKERS`, go to ACK.
- **ACK:**
  - Lasts exactly one cycle; `mc_done` is high during it.
  - Then `mc_done <= 0`, `mask <= onehot(grant)`, go to IDLE.
- **Mask:** applies only to the first IDLE cycle after ACK and is cleared on any IDLE cycle. This guards against a worker whose `jw_done` drops one cycle late.
- **Frame counting:** when the increment takes `pix_count` to `FRAME_PIXELS`, `pix_count` wraps to 0 and `frame_done` pulses in the same cycle that `mc_done` is high.
- **Ignored inputs:**
  - `wr_done` is ignored in IDLE and ACK.
  - `jw_done` changes are ignored outside IDLE.
  - Data is captured at grant, so later changes on `color`/`address` do not affect the in-flight write.
- **Reset:** `rst` in any state, including mid-WRITE, forces the following at the next edge:
  - state IDLE;
  - `mc_busy`, `mc_done`, `wr_ready`, `frame_done` = 0;
  - `wr_addr`, `wr_data`, `pix_count` = 0;
  - `rr_ptr` = 0 and `mask` = 0.

## Timing
- All outputs are registered.
- Request to write:
  - `jw_done[i]` high in IDLE cycle t gives `wr_ready`, `mc_busy[i]`, `wr_addr` and `wr_data` valid from t+1.
- Write completion:
  - `wr_done` sampled high at cycle t in WRITE gives `wr_ready = 0` and `mc_done[i] = 1` at t+1 (ACK).
  - `mc_done` falls at t+2 and the FSM is in IDLE.
- Minimum cost is 3 cycles per pixel: IDLE, WRITE with `wr_done` already high, ACK.
- Worker contract: `jw_done[i]` is deasserted by the cycle after `mc_done[i]`.
- `wr_done` may be held high. Each WRITE consumes only the first sampled high cycle, and the next WRITE is at least two cycles later.
- Simultaneous requests: the winner is the lowest index at or above `rr_ptr`. No worker waits more than `NUM_WORKERS-1` grants.

## Structure
- Package `julia_pkg` holds:
  - the state enum `mc_state_t` {IDLE, WRITE, ACK};
  - constants `NUM_WORKERS`, `FRAME_PIXELS` and `PIX_CNT_W` (19).
- Sub-module `rr_arbiter` is purely combinational, parameterised by `NUM_WORKERS`:
  - inputs `req` and `ptr`;
  - outputs a one-hot `gnt`, the binary grant index and `any`.
- The FSM, capture registers, mask and counters live in the top module.

## Test plan
- **Single request:** after reset, `jw_done = 0x0001` with `address[0] = 0x100`, `color[0] = 0xFF00FF`.
  - `wr_ready` goes high 1 cycle later with `wr_addr = 0x100`, `wr_data = 0xFF00FF` and `mc_busy = 0x0001`.
  - `wr_done` held for 1 cycle gives `mc_done = 0x0001` for exactly one cycle and `pix_count = 1`.
- **Round-robin:** `jw_done = 0xFFFF` held, with each worker dropping its own bit after its `mc_done`, and `wr_done` tied high.
  - Grant order is 0,1,...,15.
  - Exactly one `mc_done` pulse per worker, and writes spaced 3 cycles apart.
- **Fairness wrap:** `rr_ptr = 14`, requests `0x4003`.
  - Grant order is 14, 0, 1.
- **Stalled write master:** `wr_done` low for 20 cycles during WRITE.
  - `wr_ready`, `wr_addr` and `wr_data` stay stable.
  - Changing `color[g]` has no effect on `wr_data`.
  - No `mc_done` pulse occurs.
- **Frame wrap:** with `FRAME_PIXELS = 4`, complete 4 writes.
  - `frame_done` pulses together with the 4th `mc_done`.
  - `pix_count` reads 0 afterwards; the 5th write gives `pix_count = 1`.
- **Reset mid-WRITE:** assert `rst` while `wr_ready = 1`.
  - At the next edge all outputs are 0 and the FSM is in IDLE.
  - After release, a pending `jw_done = 0x0008` is granted to worker 3 (`rr_ptr` reset to 0).
